// File: rtl/eg_encoder_if.sv
// Request/serial-output bundle for the Exp-Golomb encoder.
// The master issues start/pi_data and observes the serial code stream.
// The slave is the encoder itself.
interface eg_encoder_if;
    logic       start;
    logic [3:0] pi_data;
    logic       busy;
    logic       so_data;
    logic       so_valid;
    logic       done;
    logic       err;

    modport master (
        output start,
        output pi_data,
        input  busy,
        input  so_data,
        input  so_valid,
        input  done,
        input  err
    );

    modport slave (
        input  start,
        input  pi_data,
        output busy,
        output so_data,
        output so_valid,
        output done,
        output err
    );
endinterface

// File: rtl/eg_encoder.sv
// Order-0 Exp-Golomb serial encoder with a truncated prefix (values 0..14).
// A codeword is m ones, a zero, then the low m offset bits MSB first.
// The state register names the kind of bit currently on so_data.
// Every output is registered, so nothing reaches the outputs combinationally.
module eg_encoder (
    input  logic            clk,
    input  logic            rst,
    eg_encoder_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        STOP   = 2'd2,
        SUFFIX = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] cnt;     // bits of the current field still to come after this one
    logic [1:0] m_r;     // prefix/suffix length of the codeword in flight
    logic [2:0] off_r;   // offset of the codeword in flight

    logic [1:0] m_in;
    logic [3:0] base_in;
    logic [2:0] off_in;

    // Derive m and the offset of the value being requested; 15 is rejected separately.
    always_comb begin
        m_in    = 2'd0;
        base_in = 4'd0;
        if (bus.pi_data >= 4'd7) begin
            m_in    = 2'd3;
            base_in = 4'd7;
        end else if (bus.pi_data >= 4'd3) begin
            m_in    = 2'd2;
            base_in = 4'd3;
        end else if (bus.pi_data >= 4'd1) begin
            m_in    = 2'd1;
            base_in = 4'd1;
        end
        off_in = 3'(bus.pi_data - base_in);
    end

    // Single FSM: advances one code bit per cycle and registers all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 2'd0;
            m_r          <= 2'd0;
            off_r        <= 3'd0;
            bus.busy     <= 1'b0;
            bus.so_valid <= 1'b0;
            bus.so_data  <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            bus.err <= 1'b0;
            case (state)
                IDLE: begin
                    bus.busy     <= 1'b0;
                    bus.so_valid <= 1'b0;
                    bus.so_data  <= 1'b0;
                    bus.done     <= 1'b0;
                    if (bus.start) begin
                        if (bus.pi_data == 4'd15) begin
                            bus.err <= 1'b1;
                        end else begin
                            m_r          <= m_in;
                            off_r        <= off_in;
                            bus.busy     <= 1'b1;
                            bus.so_valid <= 1'b1;
                            if (m_in == 2'd0) begin
                                // Value 0 is a lone stop bit and ends immediately.
                                state       <= STOP;
                                cnt         <= 2'd0;
                                bus.so_data <= 1'b0;
                                bus.done    <= 1'b1;
                            end else begin
                                state       <= PREFIX;
                                cnt         <= m_in - 2'd1;
                                bus.so_data <= 1'b1;
                            end
                        end
                    end
                end
                PREFIX: begin
                    if (cnt == 2'd0) begin
                        state       <= STOP;
                        bus.so_data <= 1'b0;
                    end else begin
                        cnt         <= cnt - 2'd1;
                        bus.so_data <= 1'b1;
                    end
                end
                STOP: begin
                    if (m_r == 2'd0) begin
                        state        <= IDLE;
                        bus.busy     <= 1'b0;
                        bus.so_valid <= 1'b0;
                        bus.so_data  <= 1'b0;
                        bus.done     <= 1'b0;
                    end else begin
                        state       <= SUFFIX;
                        cnt         <= m_r - 2'd1;
                        bus.so_data <= off_r[m_r - 2'd1];
                        bus.done    <= (m_r == 2'd1);
                    end
                end
                SUFFIX: begin
                    if (cnt == 2'd0) begin
                        state        <= IDLE;
                        bus.busy     <= 1'b0;
                        bus.so_valid <= 1'b0;
                        bus.so_data  <= 1'b0;
                        bus.done     <= 1'b0;
                    end else begin
                        cnt         <= cnt - 2'd1;
                        bus.so_data <= off_r[cnt - 2'd1];
                        bus.done    <= (cnt == 2'd1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/eg_encoder.md
EG_ENCODER -- requirements
Module: eg_encoder

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request to encode pi_data; sampled only when busy=0.
REQ-005 pi_data  input  4  unsigned value to encode; legal range 0..14.
REQ-006 busy  output  1  high while a codeword is being shifted out.
REQ-007 so_data  output  1  serial code bit, valid when so_valid=1.
REQ-008 so_valid  output  1  high for exactly one cycle per emitted code bit.
REQ-009 done  output  1  one-cycle pulse coincident with the last code bit.
REQ-010 err  output  1  one-cycle pulse when start captured pi_data=15.

Function
REQ-011 Coding SHALL be order-0 Exp-Golomb with a truncated prefix: m ones, one zero, then m offset bits MSB first; total 2m+1 bits.
REQ-012 m SHALL be 0 for value 0, 1 for 1..2, 2 for 3..6, 3 for 7..14.
REQ-013 offset SHALL be value-(2^m-1), 3 bits wide, and only its low m bits are sent.
REQ-014 The FSM SHALL use states IDLE, PREFIX, STOP, SUFFIX; a 2-bit counter tracks the bits left in PREFIX and SUFFIX.
REQ-015 In IDLE, start=1 with pi_data<=14 SHALL capture m and offset.
  - m=0: go to STOP.
  - m>0: go to PREFIX.
  - At the same edge: busy<=1, so_valid<=1, so_data<=first bit.
REQ-016 Latency SHALL be one cycle: the first code bit is visible in the cycle after the start-sampling edge.
REQ-017 PREFIX SHALL emit m ones (so_data=1), one per cycle, then go to STOP.
REQ-018 STOP SHALL emit one zero.
  - m=0: done=1 with that bit, then go to IDLE.
  - m>0: go to SUFFIX.
REQ-019 SUFFIX SHALL emit offset[m-1] down to offset[0], one per cycle; done=1 with offset[0]; then go to IDLE.
REQ-020 busy and so_valid SHALL be high in every cycle a code bit is presented and low in all other cycles; there are no gaps inside a codeword.
REQ-021 The edge after the last bit SHALL clear busy, so_valid, so_data and done; the next start is sampled no earlier than that following cycle.
  - Minimum start-to-start spacing: 2m+2 cycles.
REQ-022 start while busy=1 SHALL be ignored, and pi_data changes while busy=1 SHALL not affect the codeword in flight.
REQ-023 start with pi_data=15 in IDLE SHALL pulse err for one cycle (next cycle), emit no bits, leave busy=0, and stay in IDLE.
REQ-024 so_data SHALL be 0 whenever so_valid=0.
REQ-025 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-026 The emitted stream SHALL decode, through the team's Exp-Golomb decoder, back to the original pi_data for every value 0..14.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, clear the counter, offset and m, and drive busy=0, so_valid=0, so_data=0, done=0, err=0.
REQ-028 rst SHALL take priority over start and over any in-progress codeword; a partial codeword is abandoned with no done pulse.
REQ-029 In the first cycle after rst deasserts, the block SHALL accept start.

Verification
REQ-030 start, pi_data=0 -> next cycle one bit "0" with so_valid=1, busy=1, done=1; following cycle busy=0.
REQ-031 pi_data=2 -> bits 1,0,1 on consecutive cycles; done on the third bit; busy high for exactly 3 cycles.
REQ-032 pi_data=5 -> bits 1,1,0,1,0; pi_data=14 -> bits 1,1,1,0,1,1,1 with done on the 7th bit.
REQ-033 pi_data=15 -> err=1 for one cycle; so_valid, busy and done stay 0; then pi_data=7 is accepted -> bits 1,1,1,0,0,0,0.
REQ-034 start held high with varying pi_data during a pi_data=9 codeword (1,1,1,0,0,1,0) -> the codeword is unchanged; the next codeword begins 2m+2=8 cycles after the first start.
REQ-035 rst asserted on the 3rd bit of pi_data=12 -> the next cycle has all outputs 0 and no done; a start of pi_data=1 afterwards -> bits 1,0,0.
